// File: rtl/mitll_andt_sched_if.sv
// Bundle of requester handshakes, clocked-AND cell pulses and the response bus.
// The slave modport is the scheduler side; the master modport is the side that drives it.
interface mitll_andt_sched_if;
  logic       req0_valid;
  logic       req1_valid;
  logic       req0_a;
  logic       req0_b;
  logic       req1_a;
  logic       req1_b;
  logic       req0_ready;
  logic       req1_ready;
  logic       cell_a;
  logic       cell_b;
  logic       cell_clk;
  logic       cell_out;
  logic       rsp_valid;
  logic       rsp_id;
  logic       rsp_result;
  logic       rsp_err;
  logic       err_sticky;
  logic [2:0] state_dbg;

  // A request transfers on a rising clk edge where reqN_valid and reqN_ready are
  // both high; the operands must stay stable while valid is high. The response
  // has no ready: rsp_valid is a one-cycle strobe.
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, cell_out,
    output req0_ready, req1_ready, cell_a, cell_b, cell_clk,
           rsp_valid, rsp_id, rsp_result, rsp_err, err_sticky, state_dbg
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, cell_out,
    input  req0_ready, req1_ready, cell_a, cell_b, cell_clk,
           rsp_valid, rsp_id, rsp_result, rsp_err, err_sticky, state_dbg
  );
endinterface

// File: rtl/mitll_andt_sched.sv
// Round-robin scheduler driving a toggle-encoded clocked AND cell: sends the operand
// and clock pulses, watches a timed window for the output pulse and reports the result.
module mitll_andt_sched #(
  parameter int unsigned SETUP_CYC = 3,
  parameter int unsigned PROP_CYC  = 8,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  mitll_andt_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t     state_q;
  logic [5:0] cnt_q;
  logic       ptr_q;
  logic       id_q;
  logic       a_q;
  logic       b_q;
  logic       result_q;
  logic       co_prev_q;
  logic       cell_a_q;
  logic       cell_b_q;
  logic       cell_clk_q;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic       rsp_result_q;
  logic       rsp_err_q;
  logic       sticky_q;

  logic in_idle;
  logic grant0;
  logic grant1;
  logic accept;
  logic sel_a;
  logic sel_b;
  logic cell_edge;
  logic hit;

  // ptr_q names the requester favoured on contention; grants are suppressed in reset.
  assign in_idle   = (state_q == ST_IDLE) && !rst;
  assign grant0    = in_idle && bus.req0_valid && (!bus.req1_valid || !ptr_q);
  assign grant1    = in_idle && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
  assign accept    = grant0 || grant1;
  assign sel_a     = grant1 ? bus.req1_a : bus.req0_a;
  assign sel_b     = grant1 ? bus.req1_b : bus.req0_b;
  assign cell_edge = bus.cell_out ^ co_prev_q;
  assign hit       = result_q || cell_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      result_q     <= 1'b0;
      co_prev_q    <= 1'b0;
      cell_a_q     <= 1'b0;
      cell_b_q     <= 1'b0;
      cell_clk_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      co_prev_q   <= bus.cell_out;
      rsp_valid_q <= 1'b0;
      if (cell_edge && (state_q != ST_WAIT)) sticky_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            id_q     <= grant1;
            a_q      <= sel_a;
            b_q      <= sel_b;
            cell_a_q <= cell_a_q ^ sel_a;
            cell_b_q <= cell_b_q ^ sel_b;
            ptr_q    <= !grant1;
            result_q <= 1'b0;
            cnt_q    <= 6'(SETUP_CYC);
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // The clock pulse leaves as the count reaches zero; the cell gets one
          // settle cycle (count held at zero) before the window opens.
          if (cnt_q == 6'd0) begin
            cnt_q   <= 6'(PROP_CYC);
            state_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) cell_clk_q <= !cell_clk_q;
          end
        end
        ST_WAIT: begin
          if (cell_edge) result_q <= 1'b1;
          if (cnt_q == 6'd1) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_result_q <= hit;
            rsp_err_q    <= hit ^ (a_q & b_q);
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        ST_RESP: begin
          if (HOLD_CYC == 0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= 6'(HOLD_CYC);
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q <= 6'd1) state_q <= ST_IDLE;
          else               cnt_q   <= cnt_q - 6'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.cell_a     = cell_a_q;
  assign bus.cell_b     = cell_b_q;
  assign bus.cell_clk   = cell_clk_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mitll_andt_sched.sv
// Directed bench for the clocked-AND scheduler: default-parameter instance plus a
// fast instance (SETUP_CYC=1, PROP_CYC=1, HOLD_CYC=0) sharing clock and reset.
module tb_mitll_andt_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mitll_andt_sched_if bus ();
  mitll_andt_sched_if bus2 ();

  mitll_andt_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mitll_andt_sched #(
    .SETUP_CYC (1),
    .PROP_CYC  (1),
    .HOLD_CYC  (0)
  ) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];  // {rsp_id, rsp_result, rsp_err}

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = 1'b0; bus.req0_b = 1'b0; bus.req1_a = 1'b0; bus.req1_b = 1'b0;
    bus2.req0_valid = 1'b0; bus2.req1_valid = 1'b0;
    bus2.req0_a = 1'b0; bus2.req0_b = 1'b0; bus2.req1_a = 1'b0; bus2.req1_b = 1'b0;
  endtask

  // Called at cycle 0 of a transaction; returns at cycle 16 (idle again).
  task automatic run_txn(input string name, input logic id, input logic a, input logic b,
                         input int tog_cyc, input int spur_cyc,
                         input logic exp_res, input logic exp_sticky);
    logic sa, sb, sc, nc, ea, eb;
    logic [2:0] e;
    sa = bus.cell_a; sb = bus.cell_b; sc = bus.cell_clk;
    nc = ~sc; ea = sa ^ a; eb = sb ^ b;
    e  = 3'b000;
    exp_q.push_back({id, exp_res, exp_res ^ (a & b)});
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
    #1;
    chk({name, "_ready_sel"},   id ? bus.req1_ready : bus.req0_ready, 1);
    chk({name, "_ready_other"}, id ? bus.req0_ready : bus.req1_ready, 0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      step();
      if (cyc == 1) begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk({name, "_cell_a_c1"},   bus.cell_a,   ea);
        chk({name, "_cell_b_c1"},   bus.cell_b,   eb);
        chk({name, "_cell_clk_c1"}, bus.cell_clk, sc);
      end
      if (cyc == 3)  chk({name, "_cell_clk_c3"}, bus.cell_clk, sc);
      if (cyc == 4)  chk({name, "_cell_clk_c4"}, bus.cell_clk, nc);
      if (cyc == 12) chk({name, "_rsp_valid_c12"}, bus.rsp_valid, 0);
      if (cyc == 13) begin
        chk({name, "_rsp_valid_c13"}, bus.rsp_valid, 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({name, "_rsp_id"},     bus.rsp_id,     e[2]);
        chk({name, "_rsp_result"}, bus.rsp_result, e[1]);
        chk({name, "_rsp_err"},    bus.rsp_err,    e[0]);
      end
      if (cyc == 14) begin
        chk({name, "_rsp_valid_c14"},  bus.rsp_valid,  0);
        chk({name, "_rsp_result_c14"}, bus.rsp_result, e[1]);
      end
      if (cyc == 15) chk({name, "_state_hold"}, bus.state_dbg, 3'd4);
      if (cyc == 16) begin
        chk({name, "_state_idle"}, bus.state_dbg, 3'd0);
        chk({name, "_err_sticky"}, bus.err_sticky, exp_sticky);
      end
      if (cyc == tog_cyc || cyc == spur_cyc) bus.cell_out = ~bus.cell_out;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic er0, er1, seen;
    rst = 1'b1;
    drive_idle();
    bus.cell_out  = 1'b0;
    bus2.cell_out = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    step(); step();
    chk("rst_ready0",     bus.req0_ready, 0);
    chk("rst_ready1",     bus.req1_ready, 0);
    chk("rst_cell_a",     bus.cell_a,     0);
    chk("rst_cell_clk",   bus.cell_clk,   0);
    chk("rst_rsp_valid",  bus.rsp_valid,  0);
    chk("rst_err_sticky", bus.err_sticky, 0);
    chk("rst_state",      bus.state_dbg,  3'd0);
    rst = 1'b0;

    // Contention: both valid continuously, grants every 16 cycles alternating.
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) step();
      er0 = (c % 16 == 0) && ((c / 16) % 2 == 0);
      er1 = (c % 16 == 0) && ((c / 16) % 2 == 1);
      chk($sformatf("rr_ready0_c%0d", c), bus.req0_ready, er0);
      chk($sformatf("rr_ready1_c%0d", c), bus.req1_ready, er1);
      if (c % 16 == 13) begin
        chk($sformatf("rr_rsp_valid_c%0d", c), bus.rsp_valid, 1);
        chk($sformatf("rr_rsp_id_c%0d", c),    bus.rsp_id,    (c / 16) % 2);
      end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step();

    // Single request, zero product, silent cell with a spurious early edge.
    run_txn("single", 1'b0, 1'b1, 1'b1, 7,  -1, 1'b1, 1'b0);
    run_txn("zero",   1'b1, 1'b1, 1'b0, -1, -1, 1'b0, 1'b0);
    run_txn("fault",  1'b0, 1'b1, 1'b1, -1, 2,  1'b0, 1'b1);

    // Reset at cycle 6 of a transaction.
    bus.req0_valid = 1'b1; bus.req0_a = 1'b0; bus.req0_b = 1'b1;
    #1;
    chk("mid_ready0", bus.req0_ready, 1);
    step();
    bus.req0_valid = 1'b0;
    repeat (5) step();
    #2;
    rst = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("mid_rst_cell_a",     bus.cell_a,     0);
    chk("mid_rst_cell_b",     bus.cell_b,     0);
    chk("mid_rst_cell_clk",   bus.cell_clk,   0);
    chk("mid_rst_rsp_err",    bus.rsp_err,    0);
    chk("mid_rst_err_sticky", bus.err_sticky, 0);
    chk("mid_rst_ready1",     bus.req1_ready, 0);
    chk("mid_rst_state",      bus.state_dbg,  3'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready1_alone", bus.req1_ready, 1);
    bus.req0_valid = 1'b1;
    #1;
    chk("post_rst_ready0_both", bus.req0_ready, 1);
    chk("post_rst_ready1_both", bus.req1_ready, 0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      seen = seen | bus.rsp_valid;
    end
    chk("post_rst_no_rsp", seen, 0);

    // Fast parameter set: valid held high, next grant at cycle 5.
    bus2.req0_valid = 1'b1; bus2.req0_a = 1'b1; bus2.req0_b = 1'b1;
    #1;
    chk("fast_ready_c0", bus2.req0_ready, 1);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      step();
      chk($sformatf("fast_ready_c%0d", cyc), bus2.req0_ready, (cyc == 5));
      if (cyc == 1) begin
        chk("fast_cell_a_c1",   bus2.cell_a,   1);
        chk("fast_cell_clk_c1", bus2.cell_clk, 0);
      end
      if (cyc == 2) chk("fast_cell_clk_c2",  bus2.cell_clk,  1);
      if (cyc == 3) chk("fast_rsp_valid_c3", bus2.rsp_valid, 0);
      if (cyc == 4) begin
        chk("fast_rsp_valid_c4",  bus2.rsp_valid,  1);
        chk("fast_rsp_result_c4", bus2.rsp_result, 0);
        chk("fast_rsp_err_c4",    bus2.rsp_err,    1);
      end
    end
    bus2.req0_valid = 1'b0;

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
